// File: rtl/twiddle_fetch.sv
// Quarter-wave twiddle ROM read master: two ROM reads per index k, quadrant
// symmetry applied, complex W^k returned over a valid/ready handshake.
module twiddle_fetch #(
  parameter  int FFT_LENGTH = 8192,
  parameter  int FFT_DW     = 16,
  localparam int FFT_N      = $clog2(FFT_LENGTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [FFT_N-1:0]         req_k,
  output logic                     twact,
  output logic [FFT_N-3:0]         twa,
  input  logic [FFT_DW-1:0]        twdr_cos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [FFT_DW:0]   tw_re,
  output logic signed [FFT_DW:0]   tw_im
);

  typedef enum logic [2:0] {
    IDLE,
    RD_C,
    RD_S,
    CAP,
    OUT
  } state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [FFT_N-1:0]        r_k;
  logic signed [FFT_DW:0]  r_c;
  logic [FFT_N-3:0]        r_twa;
  logic signed [FFT_DW:0]  r_twRe;
  logic signed [FFT_DW:0]  r_twIm;

  logic [1:0]              w_q;
  logic [FFT_N-3:0]        w_r;
  logic [FFT_N-3:0]        w_twaSin;
  logic signed [FFT_DW:0]  w_s;
  logic signed [FFT_DW:0]  w_re;
  logic signed [FFT_DW:0]  w_im;

  assign w_q = r_k[FFT_N-1:FFT_N-2];
  assign w_r = r_k[FFT_N-3:0];

  // N/4 - r modulo the address width: N/4 itself truncates to zero.
  assign w_twaSin = {(FFT_N-2){1'b0}} - w_r;

  // At r==0 the sine read wraps to ROM[0] (1.0); the true sine there is 0.
  assign w_s = (w_r == '0) ? '0 : {1'b0, twdr_cos};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = RD_C;
      RD_C:    w_nextState = RD_S;
      RD_S:    w_nextState = CAP;
      CAP:     w_nextState = OUT;
      OUT:     if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_re = '0;
    w_im = '0;
    case (w_q)
      2'd0: begin w_re = r_c;  w_im = -w_s; end
      2'd1: begin w_re = -w_s; w_im = -r_c; end
      2'd2: begin w_re = -r_c; w_im = w_s;  end
      2'd3: begin w_re = w_s;  w_im = r_c;  end
      default: begin w_re = '0; w_im = '0; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k    <= '0;
      r_c    <= '0;
      r_twa  <= '0;
      r_twRe <= '0;
      r_twIm <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_k   <= req_k;
            r_twa <= req_k[FFT_N-3:0];
          end
        end
        RD_C: r_twa <= w_twaSin;
        RD_S: r_c   <= {1'b0, twdr_cos};
        CAP: begin
          r_twRe <= w_re;
          r_twIm <= w_im;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign twact     = (r_state == RD_C) || (r_state == RD_S);
  assign twa       = r_twa;
  assign out_valid = (r_state == OUT);
  assign tw_re     = r_twRe;
  assign tw_im     = r_twIm;

endmodule

// File: tb/tb_twiddle_fetch.sv
// Testbench for twiddle_fetch: ideal ROM, trig-identity reference model,
// directed vectors, handshake/reset corner cases and a random sweep.
module tb_twiddle_fetch;

  localparam int  N   = 8192;
  localparam int  DW  = 16;
  localparam int  KW  = 13;
  localparam int  N4  = N / 4;
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [KW-1:0]        req_k = '0;
  logic                 twact;
  logic [KW-3:0]        twa;
  logic [DW-1:0]        twdr_cos;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [DW:0]   tw_re;
  logic signed [DW:0]   tw_im;

  twiddle_fetch #(.FFT_LENGTH(N), .FFT_DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_k     (req_k),
    .twact     (twact),
    .twa       (twa),
    .twdr_cos  (twdr_cos),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tw_re     (tw_re),
    .tw_im     (tw_im)
  );

  always #5 clk = ~clk;

  // Ideal quarter-wave ROM with registered read.
  int            quarter [0:N4];
  logic [DW-1:0] romMem  [0:N4-1];
  logic [DW-1:0] romData = '0;

  always @(posedge clk) if (twact) romData <= romMem[twa];
  assign twdr_cos = romData;

  int checks = 0;
  int errors = 0;

  int  twaLog[$];
  bit  logEnable = 1'b0;
  always @(negedge clk) if (logEnable && twact) twaLog.push_back(int'(twa));

  // Full-circle cosine by cos(-x)=cos(x) and cos(pi-x)=-cos(x) folding.
  function automatic int cosTab(input int m);
    int mm;
    mm = m % N;
    if (mm < 0) mm = mm + N;
    if (mm > N / 2) mm = N - mm;
    if (mm > N4) return -quarter[N / 2 - mm];
    return quarter[mm];
  endfunction

  function automatic int modelRe(input int k);
    return cosTab(k);
  endfunction

  // -sin(x) = -cos(x - pi/2)
  function automatic int modelIm(input int k);
    return -cosTab(k - N4);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [KW-1:0] k, input int holdCycles,
                               output int re, output int im,
                               output int latency, output bit stable);
    int guard;
    re = 0; im = 0; latency = -1; stable = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_k     = k;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 0, 1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    latency = 0;
    while (!out_valid && latency < 20) begin
      @(negedge clk);
      latency++;
    end
    if (!out_valid) begin
      checkOutput("outValidTimeout", 0, 1);
      return;
    end
    re = int'(tw_re);
    im = int'(tw_im);
    stable = 1'b1;
    repeat (holdCycles) begin
      @(negedge clk);
      if (!out_valid || int'(tw_re) != re || int'(tw_im) != im) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [KW-1:0] k;
    int            expRe;
    int            expIm;
    int            expTwa0;
    int            expTwa1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  re, im, lat, g, t0, t1, re1, im1, firstIdle, secondIdle;
    bit  stable, busyOk, noOut;

    for (int i = 0; i < N4; i++) begin
      quarter[i] = $rtoi(32768.0 * $cos(2.0 * PI * i / N) + 0.5);
      romMem[i]  = quarter[i][DW-1:0];
    end
    quarter[N4] = 0;

    vecs[0] = '{k: 13'd0,    expRe: 32768,  expIm: 0,      expTwa0: 0,    expTwa1: 0};
    vecs[1] = '{k: 13'd2048, expRe: 0,      expIm: -32768, expTwa0: 0,    expTwa1: 0};
    vecs[2] = '{k: 13'd4096, expRe: -32768, expIm: 0,      expTwa0: 0,    expTwa1: 0};
    vecs[3] = '{k: 13'd6144, expRe: 0,      expIm: 32768,  expTwa0: 0,    expTwa1: 0};
    vecs[4] = '{k: 13'd1024, expRe: 23170,  expIm: -23170, expTwa0: 1024, expTwa1: 1024};
    vecs[5] = '{k: 13'd3072, expRe: -23170, expIm: -23170, expTwa0: 1024, expTwa1: 1024};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstReqReady", int'(req_ready), 1);
    checkOutput("rstOutValid", int'(out_valid), 0);
    checkOutput("rstTwact",    int'(twact),     0);
    checkOutput("rstTwa",      int'(twa),       0);
    checkOutput("rstTwRe",     int'(tw_re),     0);
    checkOutput("rstTwIm",     int'(tw_im),     0);
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      twaLog.delete();
      logEnable = 1'b1;
      applyStimulus(vecs[i].k, 0, re, im, lat, stable);
      logEnable = 1'b0;
      t0 = (twaLog.size() > 0) ? twaLog[0] : -1;
      t1 = (twaLog.size() > 1) ? twaLog[1] : -1;
      checkOutput($sformatf("vecRe[k=%0d]", vecs[i].k), re, vecs[i].expRe);
      checkOutput($sformatf("vecIm[k=%0d]", vecs[i].k), im, vecs[i].expIm);
      checkOutput($sformatf("vecLatency[k=%0d]", vecs[i].k), lat, 3);
      checkOutput($sformatf("vecTwactCycles[k=%0d]", vecs[i].k), twaLog.size(), 2);
      checkOutput($sformatf("vecTwaCos[k=%0d]", vecs[i].k), t0, vecs[i].expTwa0);
      checkOutput($sformatf("vecTwaSin[k=%0d]", vecs[i].k), t1, vecs[i].expTwa1);
      checkOutput($sformatf("vecDone[k=%0d]", vecs[i].k), int'(out_valid), 0);
    end

    // k=1: address pair 1, 2047 and model result
    twaLog.delete();
    logEnable = 1'b1;
    applyStimulus(13'd1, 0, re, im, lat, stable);
    logEnable = 1'b0;
    t0 = (twaLog.size() > 0) ? twaLog[0] : -1;
    t1 = (twaLog.size() > 1) ? twaLog[1] : -1;
    checkOutput("k1TwactCycles", twaLog.size(), 2);
    checkOutput("k1TwaCos", t0, 1);
    checkOutput("k1TwaSin", t1, 2047);
    checkOutput("k1Re", re, modelRe(1));
    checkOutput("k1Im", im, modelIm(1));

    // Backpressure with a competing request held on req_valid
    @(negedge clk);
    req_valid = 1'b1;
    req_k     = 13'd100;
    @(posedge clk);
    @(negedge clk);
    req_k = 13'd5000;
    busyOk = 1'b1;
    g = 0;
    while (!out_valid && g < 20) begin
      if (req_ready) busyOk = 1'b0;
      @(negedge clk);
      g++;
    end
    checkOutput("bpLatency", g, 3);
    checkOutput("bpBusyNotReady", int'(busyOk), 1);
    re1 = int'(tw_re);
    im1 = int'(tw_im);
    checkOutput("bpRe", re1, modelRe(100));
    checkOutput("bpIm", im1, modelIm(100));
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || req_ready || int'(tw_re) != re1 || int'(tw_im) != im1) stable = 1'b0;
    end
    checkOutput("bpHoldStable", int'(stable), 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bpReleased", int'(out_valid), 0);
    checkOutput("bpIdleReady", int'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    checkOutput("nextLatency", g, 3);
    checkOutput("nextRe", int'(tw_re), modelRe(5000));
    checkOutput("nextIm", int'(tw_im), modelIm(5000));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Back-to-back issue interval with out_ready held high
    out_ready = 1'b1;
    req_valid = 1'b1;
    req_k     = 13'd777;
    firstIdle = -1;
    secondIdle = -1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) begin
        if (firstIdle < 0) firstIdle = c;
        else if (secondIdle < 0) secondIdle = c;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checkOutput("issueInterval", secondIdle - firstIdle, 5);
    g = 0;
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    checkOutput("issueDrained", int'(req_ready), 1);

    // Async reset while in RD_S
    @(negedge clk);
    req_valid = 1'b1;
    req_k     = 13'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("preRstTwact", int'(twact), 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstOutValid", int'(out_valid), 0);
    checkOutput("midRstTwact",    int'(twact),     0);
    checkOutput("midRstReqReady", int'(req_ready), 1);
    checkOutput("midRstTwa",      int'(twa),       0);
    checkOutput("midRstTwRe",     int'(tw_re),     0);
    checkOutput("midRstTwIm",     int'(tw_im),     0);
    @(negedge clk);
    rst = 1'b0;
    noOut = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) noOut = 1'b0;
    end
    checkOutput("abortNoOutput", int'(noOut), 1);
    applyStimulus(13'd3000, 1, re, im, lat, stable);
    checkOutput("postRstRe", re, modelRe(3000));
    checkOutput("postRstIm", im, modelIm(3000));
    checkOutput("postRstLatency", lat, 3);

    // Random sweep against the reference model
    for (int n = 0; n < 2000; n++) begin
      int k;
      int hold;
      k    = int'($urandom_range(0, N - 1));
      hold = int'($urandom_range(0, 2));
      applyStimulus(k[KW-1:0], hold, re, im, lat, stable);
      checkOutput($sformatf("rndRe[k=%0d]", k), re, modelRe(k));
      checkOutput($sformatf("rndIm[k=%0d]", k), im, modelIm(k));
      checkOutput($sformatf("rndLatency[k=%0d]", k), lat, 3);
      checkOutput($sformatf("rndStable[k=%0d]", k), int'(stable), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twiddle_fetch.md
Name: twiddle_fetch

Overview:
- Read-side master for the quarter-wave twiddle cosine ROM used by the DFT datapath.
- Accepts a full-circle twiddle index k in [0, FFT_LENGTH) and issues two ROM reads: cos of the in-quadrant residue r, and cos of (FFT_LENGTH/4 - r).
- Applies quadrant symmetry to the two reads and returns the complex twiddle W^k = cos(2πk/N) - j·sin(2πk/N) through a valid/ready handshake.
- Feeds the butterfly stage; k comes from the stage address generator.

Parameters:
- FFT_LENGTH, 8192, transform length N; must be a power of two and at least 8.
- FFT_DW, 16, ROM word width; the ROM value is unsigned magnitude with 2^(FFT_DW-1) = 1.0.
- FFT_N, $clog2(FFT_LENGTH), index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active high.
- req_valid  in  1  request k is valid.
- req_ready  out  1  block can accept a request.
- req_k  in  FFT_N  twiddle index k.
- twact  out  1  ROM address-load enable.
- twa  out  FFT_N-2  ROM address.
- twdr_cos  in  FFT_DW  ROM data, valid the cycle after the address is loaded with twact=1.
- out_valid  out  1  twiddle result valid.
- out_ready  in  1  consumer accepts the result.
- tw_re  out  FFT_DW+1  signed real part, cos(2πk/N).
- tw_im  out  FFT_DW+1  signed imaginary part, -sin(2πk/N).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - req_ready=1, out_valid=0, tw_re=0, tw_im=0, twact=0, twa=0.
  - Internal k, c and s registers cleared.
  - rst mid-operation aborts the request; no output is produced for it.
- Index decode:
  - q = k[FFT_N-1:FFT_N-2].
  - r = k[FFT_N-3:0].
  - N4 = FFT_LENGTH/4.
- FSM: IDLE -> RD_C -> RD_S -> CAP -> OUT -> IDLE.
- IDLE:
  - req_ready=1, twact=0.
  - On req_valid: latch k, go to RD_C.
- RD_C:
  - twact=1, twa=r.
  - Go to RD_S.
- RD_S:
  - twdr_cos holds c=ROM[r]; latch it as c (zero-extend to FFT_DW+1).
  - twact=1, twa = (N4 - r) truncated to FFT_N-2 bits.
  - Go to CAP.
- CAP:
  - twdr_cos holds ROM[N4 - r]; take it as s (zero-extended).
  - If r==0, force s=0. The truncated address wraps to 0 and would read 1.0, so the ROM value must be ignored.
  - Register the outputs below, set out_valid=1, go to OUT.
- Quadrant mapping (cos, sin):
  - q0: (c, s)
  - q1: (-s, c)
  - q2: (-c, -s)
  - q3: (s, -c)
  - tw_re = cos; tw_im = -sin.
  - Negation is two's complement at FFT_DW+1 bits, so ±2^(FFT_DW-1) is exact with no saturation.
- OUT:
  - out_valid=1; tw_re and tw_im are held stable until out_ready=1.
  - Transfer occurs on the edge with out_valid & out_ready; then out_valid<=0, go to IDLE.
- twact is 0 in IDLE, CAP and OUT, so the ROM address register holds.
- req_ready=1 only in IDLE; req_k is ignored in all other states.
- Timing:
  - out_valid rises on the 3rd rising edge after the accept edge.
  - Minimum issue interval is 5 cycles with out_ready held at 1.
- All outputs are registered; there is no combinational path from req_* to out_*.

Test Plan:
- N=8192, DW=16, ideal ROM. k=0 -> twa=0 in RD_C, s forced to 0 -> tw_re=+32768, tw_im=0; out_valid exactly 3 edges after accept.
- k=2048, 4096, 6144 (r=0, q1..q3):
  - k=2048 -> (0, -32768).
  - k=4096 -> (-32768, 0).
  - k=6144 -> (0, +32768).
- k=1024 -> twa sequence 1024, 1024 -> (23170, -23170). k=3072 -> (-23170, -23170).
- k=1 -> twa sequence 1, 2047; twact high for exactly 2 cycles. Result equals the model built from ROM[1] and ROM[2047].
- Backpressure and ignored requests:
  - out_ready=0 for 10 cycles in OUT -> tw_re, tw_im and out_valid stable throughout.
  - req_valid=1 with a new k during the busy states -> not accepted (req_ready=0).
  - After the transfer, the next k is accepted in IDLE.
- Async reset:
  - Assert rst in RD_S -> immediately out_valid=0, twact=0, req_ready=1, outputs 0.
  - Next request after release -> correct result.
  - Random sweep of 2000 k values against the reference model.
